// File: rtl/radar_pkg.sv
// Shared radar definitions: physical constants and the emulator state encoding.
// The state encoding is reused by the tracking-unit bench to decode emu_state.
package radar_pkg;

  localparam int SPEED_OF_LIGHT_MPS = 300000000;
  localparam int US_PER_S           = 1000000;
  localparam int UM_PER_M           = 1000000;

  // One-way range covered per microsecond of round-trip light travel (150 m).
  localparam int RANGE_PER_US_M     = SPEED_OF_LIGHT_MPS / US_PER_S / 2;

  typedef enum logic [2:0] {
    EMU_IDLE    = 3'd0,
    EMU_ARMED   = 3'd1,
    EMU_DELAY   = 3'd2,
    EMU_ECHO    = 3'd3,
    EMU_HOLDOFF = 3'd4
  } emu_state_e;

endpackage

// File: rtl/radar_target_emulator_if.sv
// Radar interface between a tracking unit (master) and the target emulator (slave).
//   enable               master->slave  emulator answers pulses only when 1
//   target_load          master->slave  load target_init_distance into the range
//   target_init_distance master->slave  initial range, metres
//   closing_speed        master->slave  signed m/s, positive = approaching
//   radar_pulse_trigger  master->slave  radar pulse, level synchronous to CLK
//   radar_echo           slave->master  echo pulse
//   target_distance      slave->master  current range, metres
//   emu_state            slave->master  emulator state
//   echo_count           slave->master  echoes since reset, wrapping
interface radar_target_emulator_if;
  import radar_pkg::*;

  logic               enable;
  logic               target_load;
  logic        [31:0] target_init_distance;
  logic signed [31:0] closing_speed;
  logic               radar_pulse_trigger;
  logic               radar_echo;
  logic        [31:0] target_distance;
  emu_state_e         emu_state;
  logic        [15:0] echo_count;

  modport master (
    output enable, target_load, target_init_distance, closing_speed, radar_pulse_trigger,
    input  radar_echo, target_distance, emu_state, echo_count
  );

  modport slave (
    input  enable, target_load, target_init_distance, closing_speed, radar_pulse_trigger,
    output radar_echo, target_distance, emu_state, echo_count
  );

endinterface

// File: rtl/radar_target_motion.sv
// Target range model: integrates closing speed in micrometres and steps the
// range by one metre whenever a full metre has accumulated.
//   CLK, RST_N       clock, synchronous active-low reset
//   load             load init_distance and clear the accumulator (wins over motion)
//   init_distance    range to load, metres
//   closing_speed    signed m/s, positive = approaching (range decreases)
//   target_distance  current range, metres, saturating at 0 and 32'hFFFF_FFFF
module radar_target_motion
  import radar_pkg::*;
#(
  parameter int CLK_PERIOD_US = 1,
  parameter int MAX_SPEED     = 999999 / CLK_PERIOD_US
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               load,
  input  logic        [31:0] init_distance,
  input  logic signed [31:0] closing_speed,
  output logic        [31:0] target_distance
);

  logic [32:0] speed_mag;
  logic [31:0] speed_clamped;
  logic [31:0] inc_um;
  logic [32:0] sum_um;
  logic [31:0] acc_um;
  logic        step;
  logic        receding;

  // The clamp keeps inc_um below one metre, so at most one step per cycle.
  // speed_mag is 33 bits so that -2^31 has a representable magnitude.
  always_comb begin
    receding      = closing_speed[31];
    speed_mag     = receding ? (33'd0 - {closing_speed[31], closing_speed})
                             : {1'b0, closing_speed};
    speed_clamped = (speed_mag > 33'(MAX_SPEED)) ? 32'(MAX_SPEED) : speed_mag[31:0];
    inc_um        = speed_clamped * 32'(CLK_PERIOD_US);
    sum_um        = {1'b0, acc_um} + {1'b0, inc_um};
    step          = (sum_um >= 33'(UM_PER_M));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc_um          <= '0;
      target_distance <= '0;
    end else if (load) begin
      acc_um          <= '0;
      target_distance <= init_distance;
    end else if (step) begin
      acc_um <= 32'(sum_um - 33'(UM_PER_M));
      if (receding) begin
        if (target_distance != 32'hFFFF_FFFF) target_distance <= target_distance + 32'd1;
      end else begin
        if (target_distance != 32'd0) target_distance <= target_distance - 32'd1;
      end
    end else begin
      acc_um <= sum_um[31:0];
    end
  end

endmodule

// File: rtl/radar_target_emulator.sv
// Radar target emulator: answers a radar pulse with an echo after the
// round-trip delay of a simulated moving target.
//   CLK, RST_N  clock, synchronous active-low reset (aborts any pending echo)
//   bus         radar interface, slave side (pulse in, echo/range/state/count out)
module radar_target_emulator
  import radar_pkg::*;
#(
  parameter int CLK_PERIOD_US = 1,
  parameter int RANGE_STEP_M  = RANGE_PER_US_M * CLK_PERIOD_US,
  parameter int MAX_RANGE_M   = 300000,
  parameter int ECHO_WIDTH    = 2,
  parameter int MAX_SPEED     = 999999 / CLK_PERIOD_US
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  radar_target_emulator_if.slave  bus
);

  localparam int WCNT_W = ($clog2(ECHO_WIDTH) < 1) ? 1 : $clog2(ECHO_WIDTH);

  emu_state_e        state, state_n;
  logic [31:0]       target_distance;
  logic [31:0]       lat_dist;
  logic [32:0]       range_cnt;
  logic [32:0]       range_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [15:0]       echo_count;
  logic              radar_echo;
  logic              latch_en;
  logic              echo_start;

  radar_target_motion #(
    .CLK_PERIOD_US (CLK_PERIOD_US),
    .MAX_SPEED     (MAX_SPEED)
  ) u_motion (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .load            (bus.target_load),
    .init_distance   (bus.target_init_distance),
    .closing_speed   (bus.closing_speed),
    .target_distance (target_distance)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= EMU_IDLE;
    else        state <= state_n;
  end

  // The echo edge is the first DELAY edge whose updated range_cnt covers
  // lat_dist; with range_cnt starting at 0 this gives max(1, ceil(lat/step)).
  always_comb begin
    state_n    = state;
    range_nxt  = range_cnt + 33'(RANGE_STEP_M);
    case (state)
      EMU_IDLE:
        if (bus.enable && bus.radar_pulse_trigger) state_n = EMU_ARMED;
      EMU_ARMED:
        if (!bus.enable)                   state_n = EMU_IDLE;
        else if (!bus.radar_pulse_trigger) state_n = EMU_DELAY;
      EMU_DELAY:
        if (!bus.enable)                          state_n = EMU_IDLE;
        else if (lat_dist > 32'(MAX_RANGE_M))     state_n = EMU_HOLDOFF;
        else if (range_nxt >= {1'b0, lat_dist})   state_n = EMU_ECHO;
      EMU_ECHO:
        if (wcnt == WCNT_W'(ECHO_WIDTH - 1)) state_n = EMU_HOLDOFF;
      EMU_HOLDOFF:
        if (!bus.radar_pulse_trigger) state_n = EMU_IDLE;
      default:
        state_n = EMU_IDLE;
    endcase
    latch_en   = (state == EMU_ARMED) && (state_n == EMU_DELAY);
    echo_start = (state != EMU_ECHO) && (state_n == EMU_ECHO);
  end

  // Range latched here is the pre-motion value of this edge, and a later
  // target_load cannot disturb it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lat_dist   <= '0;
      range_cnt  <= '0;
      wcnt       <= '0;
      echo_count <= '0;
      radar_echo <= 1'b0;
    end else begin
      if (latch_en) begin
        lat_dist  <= target_distance;
        range_cnt <= '0;
      end else if (state == EMU_DELAY) begin
        range_cnt <= range_nxt;
      end
      if (echo_start) begin
        wcnt       <= '0;
        echo_count <= echo_count + 16'd1;
      end else if (state == EMU_ECHO) begin
        wcnt <= wcnt + WCNT_W'(1);
      end
      radar_echo <= (state_n == EMU_ECHO);
    end
  end

  assign bus.radar_echo      = radar_echo;
  assign bus.target_distance = target_distance;
  assign bus.emu_state       = state;
  assign bus.echo_count      = echo_count;

endmodule

// File: tb/tb_radar_target_emulator.sv
module tb_radar_target_emulator;
  import radar_pkg::*;

  typedef struct {
    longint cyc;
    int     cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;

  radar_target_emulator_if bus_if();

  radar_target_emulator dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_if)
  );

  always #5 CLK = ~CLK;

  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int     chk_cnt   = 0;
  int     pass_cnt  = 0;
  int     exp_count = 0;
  exp_t   sb[$];

  // Target model: constant speed since the last load, closed form.
  longint m_load_cyc = 0;
  longint m_init     = 0;
  longint m_speed    = 0;

  function automatic longint model_dist(input longint c);
    longint mag, steps, d;
    mag = (m_speed < 0) ? -m_speed : m_speed;
    if (mag > 999999) mag = 999999;
    steps = ((c - m_load_cyc) * mag) / 1000000;
    if (m_speed > 0)      d = (m_init > steps) ? m_init - steps : 0;
    else if (m_speed < 0) d = (m_init + steps > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_init + steps;
    else                  d = m_init;
    return d;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  task automatic do_load(input longint init, input longint speed);
    @(negedge CLK);
    bus_if.closing_speed        = 32'(speed);
    bus_if.target_init_distance = 32'(init);
    bus_if.target_load          = 1'b1;
    @(negedge CLK);
    bus_if.target_load = 1'b0;
    m_init     = init;
    m_speed    = speed;
    m_load_cyc = cyc;
  endtask

  // Trigger high for hi cycles; c0 is the cycle whose following edge samples it low.
  task automatic pulse(input int hi, input bit echo_allowed, output longint c0);
    longint lat, d;
    exp_t   e;
    @(negedge CLK);
    bus_if.radar_pulse_trigger = 1'b1;
    repeat (hi) @(negedge CLK);
    bus_if.radar_pulse_trigger = 1'b0;
    c0  = cyc;
    lat = model_dist(c0);
    if (echo_allowed && lat <= 300000) begin
      d = (lat + 149) / 150;
      if (d < 1) d = 1;
      exp_count++;
      e.cyc = c0 + 1 + d;
      e.cnt = exp_count;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (bus_if.emu_state != EMU_IDLE && i < budget) begin
      @(negedge CLK);
      i++;
    end
    check("return_to_idle", bus_if.emu_state, 0);
  endtask

  // Monitor: pops the scoreboard on every echo rising edge.
  logic   prev_echo = 1'b0;
  longint rise_cyc  = 0;
  exp_t   mon_e;
  always @(negedge CLK) begin
    if (bus_if.radar_echo && !prev_echo) begin
      rise_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_echo", cyc, -1);
      end else begin
        mon_e = sb.pop_front();
        check("echo_rise_cycle", cyc, mon_e.cyc);
        check("echo_count_at_rise", bus_if.echo_count, mon_e.cnt);
      end
    end
    if (!bus_if.radar_echo && prev_echo) check("echo_width", cyc - rise_cyc, 2);
    prev_echo = bus_if.radar_echo;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint c0;
    longint r;
    longint init, speed;
    int     hi, i;

    bus_if.enable               = 1'b0;
    bus_if.target_load          = 1'b0;
    bus_if.target_init_distance = '0;
    bus_if.closing_speed        = '0;
    bus_if.radar_pulse_trigger  = 1'b0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_echo", bus_if.radar_echo, 0);
    check("reset_distance", bus_if.target_distance, 0);
    check("reset_state", bus_if.emu_state, 0);
    check("reset_count", bus_if.echo_count, 0);
    RST_N = 1'b1;
    bus_if.enable = 1'b1;

    // Static target, long trigger.
    do_load(15000, 0);
    pulse(300, 1'b1, c0);
    wait_idle(400);
    check("count_after_first", bus_if.echo_count, 1);
    check("static_distance", bus_if.target_distance, 15000);

    // Delay rounding and minimum delay.
    do_load(15001, 0);
    pulse(4, 1'b1, c0);
    wait_idle(2500);
    do_load(0, 0);
    pulse(3, 1'b1, c0);
    wait_idle(2500);

    // Beyond listen window.
    do_load(400000, 0);
    pulse(2, 1'b1, c0);
    @(negedge CLK); check("oor_delay", bus_if.emu_state, 2);
    @(negedge CLK); check("oor_holdoff", bus_if.emu_state, 4);
    @(negedge CLK); check("oor_idle", bus_if.emu_state, 0);
    check("oor_count", bus_if.echo_count, exp_count);

    // Motion: approaching, receding saturation, clamp.
    do_load(1000, 100000);
    repeat (9) @(negedge CLK);  check("approach_n9", bus_if.target_distance, 1000);
    @(negedge CLK);             check("approach_n10", bus_if.target_distance, 999);
    repeat (10) @(negedge CLK); check("approach_n20", bus_if.target_distance, 998);
    repeat (5) @(negedge CLK);  check("approach_n25", bus_if.target_distance, 998);
    do_load(64'hFFFF_FFFE, -100000);
    repeat (9) @(negedge CLK);  check("recede_n9", bus_if.target_distance, 64'hFFFF_FFFE);
    @(negedge CLK);             check("recede_n10", bus_if.target_distance, 64'hFFFF_FFFF);
    repeat (20) @(negedge CLK); check("recede_sat", bus_if.target_distance, 64'hFFFF_FFFF);
    do_load(1000, 2000000);
    @(negedge CLK);             check("clamp_n1", bus_if.target_distance, 1000);
    @(negedge CLK);             check("clamp_n2", bus_if.target_distance, 999);
    repeat (10) @(negedge CLK); check("clamp_n12", bus_if.target_distance, 989);

    // Two pulses 2500 cycles apart on a closing target.
    do_load(30000, 300000);
    pulse(1, 1'b1, c0);
    wait_idle(2500);
    while (cyc < m_load_cyc + 2498) @(negedge CLK);
    pulse(1, 1'b1, c0);
    check("second_latch_distance", model_dist(c0), bus_if.target_distance);
    wait_idle(2500);
    check("two_pulse_count", bus_if.echo_count, exp_count);

    // Reset in DELAY aborts the echo.
    do_load(15000, 0);
    pulse(2, 1'b0, c0);
    repeat (10) @(negedge CLK);
    check("pre_reset_delay", bus_if.emu_state, 2);
    RST_N = 1'b0;
    @(negedge CLK);
    check("midrst_echo", bus_if.radar_echo, 0);
    check("midrst_state", bus_if.emu_state, 0);
    check("midrst_distance", bus_if.target_distance, 0);
    check("midrst_count", bus_if.echo_count, 0);
    RST_N = 1'b1;
    exp_count  = 0;
    m_init     = 0;
    m_speed    = 0;
    m_load_cyc = cyc;

    // enable dropped in DELAY.
    do_load(15000, 0);
    pulse(2, 1'b0, c0);
    repeat (10) @(negedge CLK);
    bus_if.enable = 1'b0;
    @(negedge CLK);
    check("disable_idle", bus_if.emu_state, 0);
    repeat (120) @(negedge CLK);
    check("disable_count", bus_if.echo_count, exp_count);
    bus_if.enable = 1'b1;

    // Trigger during ECHO, held into HOLDOFF.
    do_load(3000, 0);
    pulse(2, 1'b1, c0);
    i = 0;
    while (!bus_if.radar_echo && i < 100) begin
      @(negedge CLK);
      i++;
    end
    check("echo_seen", bus_if.radar_echo, 1);
    bus_if.radar_pulse_trigger = 1'b1;
    repeat (3) @(negedge CLK);
    check("holdoff_held", bus_if.emu_state, 4);
    @(negedge CLK);
    bus_if.radar_pulse_trigger = 1'b0;
    wait_idle(10);
    repeat (50) @(negedge CLK);
    check("echo_trigger_ignored", bus_if.echo_count, exp_count);

    // Randomized targets.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) init = longint'($urandom_range(0, 6000));
      else                           init = longint'($urandom_range(296000, 304000));
      speed = longint'($urandom_range(0, 800000)) - 400000;
      hi    = int'($urandom_range(1, 20));
      do_load(init, speed);
      repeat ($urandom_range(0, 30)) @(negedge CLK);
      pulse(hi, 1'b1, c0);
      wait_idle(2600);
      r = model_dist(cyc);
      check("random_distance", bus_if.target_distance, r);
    end

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    check("final_count", bus_if.echo_count, exp_count);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/radar_target_emulator.md
Name: radar_target_emulator

Overview:
- Radar target/echo responder for the tracking-unit radar interface: samples radar_pulse_trigger and returns radar_echo after the round-trip delay of a simulated target.
- The target range evolves with a programmable closing speed.
- Used as the bench/HIL counterpart of the tracking unit and as a stand-alone target source in the system testbench.
- Time base: 1 us timescale; speed of light 300_000_000 m/s, so round trip covers 150 m of range per us.

Parameters:
- CLK_PERIOD_US, 1, CLK period in microseconds.
- RANGE_STEP_M, 150*CLK_PERIOD_US, one-way range covered per clock by the round-trip light path.
- MAX_RANGE_M, 300000, latched range above this produces no echo (beyond the 2000 us listen window).
- ECHO_WIDTH, 2, radar_echo high time in clocks.
- MAX_SPEED, 999999/CLK_PERIOD_US, magnitude clamp for closing_speed.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- enable  in  1  emulator responds to pulses only when 1.
- target_load  in  1  loads target_init_distance into range register.
- target_init_distance  in  32  initial range, metres.
- closing_speed  in  32 signed  m/s; positive = approaching, negative = receding.
- radar_pulse_trigger  in  1  pulse from tracking unit; level, synchronous to CLK.
- radar_echo  out  1  echo pulse.
- target_distance  out  32  current range, metres.
- emu_state  out  3  IDLE=0, ARMED=1, DELAY=2, ECHO=3, HOLDOFF=4.
- echo_count  out  16  echoes emitted since reset, wraps at 16'hFFFF->0.

Behaviour:
- Reset: applied on a CLK edge with RST_N=0. Sets radar_echo=0, target_distance=0, emu_state=IDLE, echo_count=0, micrometre accumulator=0, range counter=0. Reset mid-operation aborts any pending echo immediately.
- Motion, every cycle when not loading:
  - acc_um += |clamp(closing_speed)|*CLK_PERIOD_US.
  - If acc_um >= 1_000_000: acc_um -= 1_000_000 and target_distance steps by 1 m (down if speed>0, up if speed<0).
  - Saturate at 0 and 32'hFFFF_FFFF.
  - Clamp guarantees at most one step per cycle. Speed 0 leaves acc_um unchanged.
- target_load has priority over motion: target_distance <= target_init_distance, acc_um <= 0. Allowed in any state; it does not change the range already latched for an in-flight echo.
- FSM transitions:
  - IDLE -> ARMED when enable=1 and radar_pulse_trigger sampled 1.
  - ARMED -> DELAY on the first edge with trigger sampled 0. On that edge:
    - latch lat_dist <= target_distance (value before this edge's motion update);
    - range_cnt <= 0.
  - DELAY: range_cnt += RANGE_STEP_M each edge.
    - Out of range: if lat_dist > MAX_RANGE_M, go to HOLDOFF; no echo, no count.
    - Otherwise go to ECHO on edge D, with D = max(1, ceil(lat_dist/RANGE_STEP_M)) counted from the ARMED->DELAY edge.
  - ECHO: radar_echo=1 for exactly ECHO_WIDTH cycles, registered output. echo_count increments on entry. Then -> HOLDOFF.
  - HOLDOFF: wait until radar_pulse_trigger sampled 0, then -> IDLE. Prevents re-arming on a trigger held high.
- Trigger events:
  - Trigger rising in DELAY/ECHO is ignored; one echo in flight at most.
  - A trigger already high in IDLE counts as a pulse.
- enable dropping:
  - in ARMED or DELAY: -> IDLE, no echo;
  - in ECHO: the echo completes.
- Width rules: range_cnt 33 bits, so it cannot overflow for lat_dist <= MAX_RANGE_M. acc_um 32 bits unsigned. Product |speed|*CLK_PERIOD_US fits in 32 bits because of the clamp.
- Back-to-back use: the tracking unit re-pulses after the first echo. The emulator must be back in IDLE within ECHO_WIDTH+1 cycles after echo falls, provided the trigger is low.

Decomposition:
- Shared package radar_pkg holds:
  - SPEED_OF_LIGHT_MPS=300000000;
  - US_PER_S=1000000;
  - UM_PER_M=1000000;
  - the emu_state encoding as a typedef/localparams, reused by the tracking-unit bench.
- One natural sub-module: radar_target_motion (accumulator, clamp, load, saturation) producing target_distance. The FSM, delay counter and echo generation stay in the top.

Test Plan:
- Load 15000, speed 0, 300-cycle trigger -> echo rises exactly 100 edges after the trigger-low edge, high 2 cycles, echo_count=1, target_distance=15000.
- Load 15001 -> delay 101 edges. Load 0 -> delay 1 edge.
- Load 400000 -> no echo, state passes DELAY->HOLDOFF->IDLE, echo_count unchanged.
- Load 1000, speed +100000, CLK_PERIOD_US=1 -> target_distance decrements by 1 every 10 cycles. Speed -100000 from 32'hFFFF_FFFE saturates at 32'hFFFF_FFFF. Speed 2000000 clamps to a 1 m step every cycle.
- Two pulses 2500 cycles apart, load 30000, speed 300000 -> first echo after 200 edges; second lat_dist 29250 -> 195 edges; echo_count=2.
- Deassert RST_N during DELAY -> next edge: radar_echo=0, state IDLE, target_distance=0, echo_count=0. enable=0 mid-DELAY -> no echo, IDLE. Trigger pulse during ECHO -> ignored.
